msrv32_branch_predict_unit: RTL and testbench

- Parametrised successor to the combinational branch-decision logic.
- Resolves conditional branches and JAL/JALR in execute, and keeps a direct-mapped branch history table (BHT) of saturating counters.
- Fetch reads the BHT for a prediction; execute writes back each resolved outcome.
- Flags mispredictions one cycle after resolution, and keeps saturating branch and mispredict statistics.

---
 rtl/msrv32_branch_predict_unit.sv | 164 ++++++++++++++++
 tb/tb_msrv32_branch_predict_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_branch_predict_unit.sv
// Branch resolution plus a direct-mapped BHT of saturating counters.
// Fetch reads a prediction, execute resolves outcomes, and the unit tracks mispredict statistics.
module msrv32_branch_predict_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              clear_in,
  output logic              ready_out,
  input  logic              pred_req_in,
  input  logic [PC_W-1:0]   pred_pc_in,
  output logic              pred_valid_out,
  output logic              pred_taken_out,
  input  logic              res_valid_in,
  input  logic [PC_W-1:0]   res_pc_in,
  input  logic [4:0]        opcode_in,
  input  logic [2:0]        funct3_in,
  input  logic [XLEN-1:0]   rs1_in,
  input  logic [XLEN-1:0]   rs2_in,
  input  logic              res_pred_taken_in,
  output logic              branch_taken_out,
  output logic              res_done_out,
  output logic              mispredict_out,
  output logic [STAT_W-1:0] branch_count_out,
  output logic [STAT_W-1:0] mispredict_count_out
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((2 ** (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MIN = '0;

  logic [0:0]       state, state_d;
  logic [IDX_W-1:0] init_idx, init_idx_d;

  logic [IDX_W-1:0] pred_idx, res_idx;
  logic             is_branch, is_jump, res_mispredict;

  logic [CNT_W-1:0] bht [DEPTH];
  logic             bht_we;
  logic [IDX_W-1:0] bht_widx;
  logic [CNT_W-1:0] bht_wdata, bht_cur;

  assign pred_idx  = pred_pc_in[IDX_W+1:2];
  assign res_idx   = res_pc_in[IDX_W+1:2];
  assign is_branch = (opcode_in == OP_BRANCH);
  assign is_jump   = (opcode_in == OP_JAL) || (opcode_in == OP_JALR);
  assign bht_cur   = bht[res_idx];
  assign ready_out = (state == ST_RUN);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      state    <= state_d;
      init_idx <= init_idx_d;
    end
  end

  // Next state: sweep the table once, then run until cleared
  always_comb begin
    state_d    = state;
    init_idx_d = init_idx;
    if (clear_in) begin
      state_d    = ST_INIT;
      init_idx_d = '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx_d = init_idx + IDX_W'(1);
          if (init_idx == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Actual branch outcome
  always_comb begin
    branch_taken_out = 1'b0;
    if (is_jump) begin
      branch_taken_out = 1'b1;
    end else if (is_branch) begin
      case (funct3_in)
        3'b000:  branch_taken_out = (rs1_in == rs2_in);
        3'b001:  branch_taken_out = (rs1_in != rs2_in);
        3'b100:  branch_taken_out = ($signed(rs1_in) <  $signed(rs2_in));
        3'b101:  branch_taken_out = ($signed(rs1_in) >= $signed(rs2_in));
        3'b110:  branch_taken_out = (rs1_in <  rs2_in);
        3'b111:  branch_taken_out = (rs1_in >= rs2_in);
        default: branch_taken_out = 1'b0;
      endcase
    end
  end

  assign res_mispredict = res_valid_in && (is_branch || is_jump) &&
                          (res_pred_taken_in != branch_taken_out);

  // Single BHT write port: init sweep in INIT, counter update in RUN
  always_comb begin
    bht_we    = 1'b0;
    bht_widx  = res_idx;
    bht_wdata = bht_cur;
    if (state == ST_INIT) begin
      bht_we    = 1'b1;
      bht_widx  = init_idx;
      bht_wdata = CNT_WNT;
    end else if (res_valid_in && is_branch) begin
      bht_we = 1'b1;
      if (branch_taken_out) begin
        bht_wdata = (bht_cur == CNT_MAX) ? bht_cur : bht_cur + CNT_W'(1);
      end else begin
        bht_wdata = (bht_cur == CNT_MIN) ? bht_cur : bht_cur - CNT_W'(1);
      end
    end
  end

  // Table storage is fully rewritten by the init sweep, so it carries no reset
  always_ff @(posedge clk_in) begin
    if (bht_we) bht[bht_widx] <= bht_wdata;
  end

  // Registered prediction, resolution pulses and statistics
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pred_valid_out       <= 1'b0;
      pred_taken_out       <= 1'b0;
      res_done_out         <= 1'b0;
      mispredict_out       <= 1'b0;
      branch_count_out     <= '0;
      mispredict_count_out <= '0;
    end else begin
      pred_valid_out <= (state == ST_RUN) && pred_req_in;
      pred_taken_out <= (state == ST_RUN) && pred_req_in && bht[pred_idx][CNT_W-1];
      res_done_out   <= res_valid_in;
      mispredict_out <= res_mispredict;
      if (clear_in) begin
        branch_count_out     <= '0;
        mispredict_count_out <= '0;
      end else begin
        if (res_valid_in && is_branch && (branch_count_out != '1))
          branch_count_out <= branch_count_out + STAT_W'(1);
        if (res_mispredict && (mispredict_count_out != '1))
          mispredict_count_out <= mispredict_count_out + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_msrv32_branch_predict_unit.sv
// Directed self-checking bench for msrv32_branch_predict_unit.
module tb_msrv32_branch_predict_unit;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_ALU    = 5'b01100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        ready;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        pred_valid, pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        res_pred_taken;
  logic        branch_taken, res_done, mispredict;
  logic [15:0] branch_count, mispredict_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_br  = 0;
  int exp_mp  = 0;

  msrv32_branch_predict_unit dut (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .clear_in             (clear),
    .ready_out            (ready),
    .pred_req_in          (pred_req),
    .pred_pc_in           (pred_pc),
    .pred_valid_out       (pred_valid),
    .pred_taken_out       (pred_taken),
    .res_valid_in         (res_valid),
    .res_pc_in            (res_pc),
    .opcode_in            (opcode),
    .funct3_in            (funct3),
    .rs1_in               (rs1),
    .rs2_in               (rs2),
    .res_pred_taken_in    (res_pred_taken),
    .branch_taken_out     (branch_taken),
    .res_done_out         (res_done),
    .mispredict_out       (mispredict),
    .branch_count_out     (branch_count),
    .mispredict_count_out (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic [31:0] pc, input logic exp_taken, input string tag);
    pred_req = 1'b1;
    pred_pc  = pc;
    tick();
    check_eq({tag, "_valid"}, 32'(pred_valid), 32'd1);
    check_eq({tag, "_taken"}, 32'(pred_taken), 32'(exp_taken));
    pred_req = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [4:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic pt,
                         input logic exp_taken, input logic exp_mis, input string tag);
    res_valid      = 1'b1;
    res_pc         = pc;
    opcode         = op;
    funct3         = f3;
    rs1            = a;
    rs2            = b;
    res_pred_taken = pt;
    #1;
    check_eq({tag, "_taken"}, 32'(branch_taken), 32'(exp_taken));
    tick();
    if (op == OP_BRANCH) exp_br++;
    if (exp_mis) exp_mp++;
    check_eq({tag, "_done"}, 32'(res_done), 32'd1);
    check_eq({tag, "_mis"}, 32'(mispredict), 32'(exp_mis));
    check_eq({tag, "_brcnt"}, 32'(branch_count), 32'(exp_br));
    check_eq({tag, "_mpcnt"}, 32'(mispredict_count), 32'(exp_mp));
    res_valid = 1'b0;
  endtask

  task automatic comb_outcome(input logic [4:0] op, input logic [2:0] f3, input logic exp, input string tag);
    opcode = op;
    funct3 = f3;
    #1;
    check_eq(tag, 32'(branch_taken), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; pred_req = 1'b0; pred_pc = '0;
    res_valid = 1'b0; res_pc = '0; opcode = '0; funct3 = '0;
    rs1 = '0; rs2 = '0; res_pred_taken = 1'b0;

    #12;
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_pvalid", 32'(pred_valid), 32'd0);
    check_eq("rst_done", 32'(res_done), 32'd0);
    check_eq("rst_brcnt", 32'(branch_count), 32'd0);
    check_eq("rst_mpcnt", 32'(mispredict_count), 32'd0);

    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      check_eq($sformatf("init_ready_%0d", i), 32'(ready), 32'(i == 64));
    end

    predict(32'h100, 1'b0, "first_pred");
    tick();
    check_eq("pred_valid_idle", 32'(pred_valid), 32'd0);

    // Entry 0 saturates at 11, alias 0x200 shares it
    resolve(32'h100, OP_BRANCH, 3'b000, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, "beq1");
    resolve(32'h100, OP_BRANCH, 3'b000, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, "beq2");
    resolve(32'h100, OP_BRANCH, 3'b000, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, "beq3");
    predict(32'h100, 1'b1, "sat_pred");
    predict(32'h200, 1'b1, "alias_pred");
    resolve(32'h100, OP_BRANCH, 3'b001, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, "bne_dec1");
    predict(32'h100, 1'b1, "dec1_pred");
    resolve(32'h100, OP_BRANCH, 3'b001, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, "bne_dec2");
    predict(32'h100, 1'b0, "dec2_pred");

    rs1 = 32'hFFFF_FFFF;
    rs2 = 32'd1;
    comb_outcome(OP_BRANCH, 3'b100, 1'b1, "blt");
    comb_outcome(OP_BRANCH, 3'b101, 1'b0, "bge");
    comb_outcome(OP_BRANCH, 3'b110, 1'b0, "bltu");
    comb_outcome(OP_BRANCH, 3'b111, 1'b1, "bgeu");
    comb_outcome(OP_BRANCH, 3'b010, 1'b0, "f3_010");
    comb_outcome(OP_BRANCH, 3'b011, 1'b0, "f3_011");
    comb_outcome(OP_BRANCH, 3'b000, 1'b0, "beq_ne");
    comb_outcome(OP_BRANCH, 3'b001, 1'b1, "bne_ne");
    comb_outcome(OP_JAL, 3'b000, 1'b1, "jal");
    comb_outcome(OP_JALR, 3'b000, 1'b1, "jalr");
    comb_outcome(OP_ALU, 3'b000, 1'b0, "alu_op");

    resolve(32'h108, OP_BRANCH, 3'b001, 32'd7, 32'd7, 1'b1, 1'b0, 1'b1, "bne_mis");
    resolve(32'h10C, OP_JALR, 3'b000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, "jalr_mis");
    predict(32'h10C, 1'b0, "jalr_noupd");
    resolve(32'h110, OP_ALU, 3'b000, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, "alu_res");
    tick();
    check_eq("done_pulse", 32'(res_done), 32'd0);

    // Same-cycle predict and taken update on entry 1
    pred_req = 1'b1; pred_pc = 32'h104;
    res_valid = 1'b1; res_pc = 32'h104; opcode = OP_BRANCH; funct3 = 3'b000;
    rs1 = 32'd5; rs2 = 32'd5; res_pred_taken = 1'b0;
    tick();
    exp_br++; exp_mp++;
    check_eq("coll_pvalid", 32'(pred_valid), 32'd1);
    check_eq("coll_ptaken", 32'(pred_taken), 32'd0);
    check_eq("coll_mis", 32'(mispredict), 32'd1);
    check_eq("coll_mpcnt", 32'(mispredict_count), 32'(exp_mp));
    pred_req = 1'b0; res_valid = 1'b0;
    tick();
    check_eq("coll_mis_pulse", 32'(mispredict), 32'd0);
    predict(32'h104, 1'b1, "coll_after");

    // Clear in RUN, with a resolve and a predict landing inside the sweep
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_br = 0; exp_mp = 0;
    check_eq("clr_ready", 32'(ready), 32'd0);
    check_eq("clr_brcnt", 32'(branch_count), 32'd0);
    check_eq("clr_mpcnt", 32'(mispredict_count), 32'd0);
    for (int i = 1; i <= 64; i++) begin
      if (i == 10) begin
        res_valid = 1'b1; res_pc = 32'h100; opcode = OP_BRANCH; funct3 = 3'b000;
        rs1 = 32'd3; rs2 = 32'd3; res_pred_taken = 1'b0;
      end
      if (i == 20) begin
        pred_req = 1'b1; pred_pc = 32'h100;
      end
      tick();
      check_eq($sformatf("clr_ready_%0d", i), 32'(ready), 32'(i == 64));
      if (i == 10) begin
        check_eq("init_res_done", 32'(res_done), 32'd1);
        check_eq("init_res_mis", 32'(mispredict), 32'd1);
        check_eq("init_brcnt", 32'(branch_count), 32'd1);
        check_eq("init_mpcnt", 32'(mispredict_count), 32'd1);
        res_valid = 1'b0;
      end
      if (i == 20) begin
        check_eq("init_pvalid", 32'(pred_valid), 32'd0);
        pred_req = 1'b0;
      end
    end
    predict(32'h104, 1'b0, "clr_entry1");
    predict(32'h100, 1'b0, "init_upd_dropped");

    // Async reset in the middle of a sweep
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick(); tick();
    res_valid = 1'b1; res_pc = 32'h0; opcode = OP_JAL; funct3 = 3'b000; res_pred_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    check_eq("pre_rst_mpcnt", 32'(mispredict_count), 32'd1);
    check_eq("pre_rst_done", 32'(res_done), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ready", 32'(ready), 32'd0);
    check_eq("arst_done", 32'(res_done), 32'd0);
    check_eq("arst_mis", 32'(mispredict), 32'd0);
    check_eq("arst_mpcnt", 32'(mispredict_count), 32'd0);
    check_eq("arst_brcnt", 32'(branch_count), 32'd0);
    tick();
    check_eq("arst_hold_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      check_eq($sformatf("reinit_ready_%0d", i), 32'(ready), 32'(i == 64));
    end
    predict(32'h100, 1'b0, "reinit_pred");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
